// File: rtl/adc_turn_sequencer_if.sv
// Signal bundle between the turn sequencer, the ADC and the game logic.
// The master modport is the sequencer; the slave modport is its environment.
interface adc_turn_sequencer_if;
    logic       enable;
    logic       screen_end;
    logic       eoc;
    logic [7:0] adc_data;
    logic       player;
    logic       adc_start;
    logic [7:0] speed_p0;
    logic [7:0] speed_p1;
    logic       move_valid;
    logic [9:0] move_delta;
    logic       timeout_err;
    logic       busy;

    modport master (
        input  enable, screen_end, eoc, adc_data,
        output player, adc_start, speed_p0, speed_p1,
               move_valid, move_delta, timeout_err, busy
    );

    modport slave (
        output enable, screen_end, eoc, adc_data,
        input  player, adc_start, speed_p0, speed_p1,
               move_valid, move_delta, timeout_err, busy
    );
endinterface

// File: rtl/adc_turn_sequencer.sv
// Alternates ADC conversions between two players and turns each captured
// sample into one signed X move, released on the next frame boundary.
module adc_turn_sequencer #(
    parameter int START_CYCLES   = 12,
    parameter int SETTLE_CYCLES  = 100,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int SPEED_SHIFT    = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    adc_turn_sequencer_if.master bus
);
    localparam int MAX_A   = (START_CYCLES > SETTLE_CYCLES) ? START_CYCLES : SETTLE_CYCLES;
    localparam int MAX_CNT = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t START_LAST   = cnt_t'(START_CYCLES - 1);
    localparam cnt_t SETTLE_LAST  = cnt_t'(SETTLE_CYCLES - 1);
    localparam cnt_t TIMEOUT_LAST = cnt_t'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, SETTLE, START, WAIT_EOC, HOLD} state_e;

    state_e     state_q, state_d;
    cnt_t       cnt_q, cnt_d;
    logic       player_q, player_d;
    logic       adc_start_q, adc_start_d;
    logic [7:0] speed_p0_q, speed_p0_d;
    logic [7:0] speed_p1_q, speed_p1_d;
    logic       pending_q, pending_d;
    logic       pend_player_q, pend_player_d;
    logic       move_valid_q, move_valid_d;
    logic [9:0] move_delta_q, move_delta_d;
    logic       timeout_err_q, timeout_err_d;
    logic       busy_q, busy_d;
    logic       eoc_s1_q, eoc_s2_q, eoc_prev_q;

    logic       eoc_edge;
    logic [7:0] pend_sample;
    logic [9:0] mag;

    assign eoc_edge    = eoc_s2_q & ~eoc_prev_q;
    assign pend_sample = pend_player_q ? speed_p1_q : speed_p0_q;
    assign mag         = {2'b00, pend_sample >> SPEED_SHIFT};

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        player_d      = player_q;
        adc_start_d   = adc_start_q;
        speed_p0_d    = speed_p0_q;
        speed_p1_d    = speed_p1_q;
        pending_d     = pending_q;
        pend_player_d = pend_player_q;
        move_valid_d  = 1'b0;
        move_delta_d  = move_delta_q;
        timeout_err_d = timeout_err_q;

        if (!bus.enable) begin
            // Dropping enable aborts everything except the retained results.
            state_d     = IDLE;
            cnt_d       = '0;
            adc_start_d = 1'b0;
            pending_d   = 1'b0;
        end else begin
            // pending_q is still clear in the capture cycle, so a coincident
            // frame boundary naturally defers the strobe by one frame.
            if (bus.screen_end && pending_q) begin
                move_valid_d = 1'b1;
                pending_d    = 1'b0;
                move_delta_d = pend_player_q ? (~mag + 10'd1) : mag;
            end
            case (state_q)
                IDLE: begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                end
                SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        state_d     = START;
                        cnt_d       = '0;
                        adc_start_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + cnt_t'(1);
                    end
                end
                START: begin
                    if (cnt_q == START_LAST) begin
                        state_d     = WAIT_EOC;
                        cnt_d       = '0;
                        adc_start_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + cnt_t'(1);
                    end
                end
                WAIT_EOC: begin
                    if (eoc_edge) begin
                        if (player_q) speed_p1_d = bus.adc_data;
                        else          speed_p0_d = bus.adc_data;
                        pending_d     = 1'b1;
                        pend_player_d = player_q;
                        state_d       = HOLD;
                        cnt_d         = '0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        timeout_err_d = 1'b1;
                        state_d       = SETTLE;
                        cnt_d         = '0;
                    end else begin
                        cnt_d = cnt_q + cnt_t'(1);
                    end
                end
                HOLD: begin
                    if (!pending_q) begin
                        player_d = ~player_q;
                        state_d  = SETTLE;
                        cnt_d    = '0;
                    end
                end
                default: begin
                    state_d     = IDLE;
                    cnt_d       = '0;
                    adc_start_d = 1'b0;
                end
            endcase
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            player_q      <= 1'b0;
            adc_start_q   <= 1'b0;
            speed_p0_q    <= '0;
            speed_p1_q    <= '0;
            pending_q     <= 1'b0;
            pend_player_q <= 1'b0;
            move_valid_q  <= 1'b0;
            move_delta_q  <= '0;
            timeout_err_q <= 1'b0;
            busy_q        <= 1'b0;
            eoc_s1_q      <= 1'b0;
            eoc_s2_q      <= 1'b0;
            eoc_prev_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            player_q      <= player_d;
            adc_start_q   <= adc_start_d;
            speed_p0_q    <= speed_p0_d;
            speed_p1_q    <= speed_p1_d;
            pending_q     <= pending_d;
            pend_player_q <= pend_player_d;
            move_valid_q  <= move_valid_d;
            move_delta_q  <= move_delta_d;
            timeout_err_q <= timeout_err_d;
            busy_q        <= busy_d;
            eoc_s1_q      <= bus.eoc;
            eoc_s2_q      <= eoc_s1_q;
            eoc_prev_q    <= eoc_s2_q;
        end
    end

    assign bus.player      = player_q;
    assign bus.adc_start   = adc_start_q;
    assign bus.speed_p0    = speed_p0_q;
    assign bus.speed_p1    = speed_p1_q;
    assign bus.move_valid  = move_valid_q;
    assign bus.move_delta  = move_delta_q;
    assign bus.timeout_err = timeout_err_q;
    assign bus.busy        = busy_q;
endmodule
